// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that lets NREQ producers share one FIFO write port, in bursts of up to BURST_LEN beats.
// Writes are withheld while the FIFO is full or its level has reached AF_TH.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int AF_TH     = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    wr_en,
  output logic [DW-1:0]           buf_in,
  input  logic                    buf_full,
  input  logic [3:0]              fifo_counter,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, owner, owner_nx;
  logic [PW-1:0] win, cand, sel;
  logic [3:0]    beat, beat_nx;
  logic          space_ok, found, ready_bit, xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (int'(p) >= NREQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // First valid producer at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign space_ok  = !buf_full && (int'(fifo_counter) < AF_TH);
  assign sel       = (state == BURST) ? owner : win;
  // Gating with rst keeps ready low for the whole asynchronous reset window.
  assign ready_bit = rst && space_ok && ((state == BURST) || found);
  assign xfer      = ready_bit && req_valid[sel];
  assign busy      = (state == BURST);
  assign grant_id  = owner;

  always_comb begin
    req_ready = '0;
    if (ready_bit) req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    beat_nx  = beat;
    case (state)
      IDLE: begin
        if (xfer) begin
          owner_nx = win;
          if (BURST_LEN == 1) begin
            ptr_nx = wrap_inc(win);
          end else begin
            state_nx = BURST;
            beat_nx  = 4'd1;
          end
        end
      end
      BURST: begin
        if (!req_valid[owner]) begin
          state_nx = IDLE;
          ptr_nx   = wrap_inc(owner);
        end else if (xfer) begin
          beat_nx = beat + 4'd1;
          if (int'(beat) + 1 >= BURST_LEN) begin
            state_nx = IDLE;
            ptr_nx   = wrap_inc(owner);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      beat   <= '0;
      wr_en  <= 1'b0;
      buf_in <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      beat  <= beat_nx;
      wr_en <= xfer;
      if (xfer) buf_in <= req_data[int'(sel)*DW +: DW];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with default parameters (4 producers, bursts of 4, AF_TH 14).
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wr_en;
  logic [7:0]  buf_in;
  logic        buf_full;
  logic [3:0]  fifo_counter;
  logic [1:0]  grant_id;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  fifo_wr_arb dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_en        (wr_en),
    .buf_in       (buf_in),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset is released between clock edges.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
  endtask

  task automatic drop_case(input logic [3:0] v_after, input int exp_win);
    do_reset();
    req_data  = {8'h43, 8'h42, 8'h41, 8'h40};
    req_valid = 4'b1100;
    #1 chk("drop_ready0", 32'(req_ready), 4);
    cyc();
    chk("drop_gid", 32'(grant_id), 2);
    chk("drop_busy1", 32'(busy), 1);
    cyc();
    chk("drop_buf2", 32'(buf_in), 'h42);
    req_valid = v_after;
    #1 chk("drop_busy_hold", 32'(busy), 1);
    cyc();
    chk("drop_idle", 32'(busy), 0);
    chk("drop_nowr", 32'(wr_en), 0);
    chk("drop_next_ready", 32'(req_ready), 1 << exp_win);
    cyc();
    chk("drop_next_gid", 32'(grant_id), exp_win);
    chk("drop_next_wr", 32'(wr_en), 1);
    chk("drop_next_buf", 32'(buf_in), 'h40 + exp_win);
  endtask

  int exp_id;

  initial begin
    rst          = 1'b0;
    req_valid    = 4'b1111;
    req_data     = 32'h0;
    buf_full     = 1'b0;
    fifo_counter = 4'd0;

    // Reset state, with every producer requesting
    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr", 32'(wr_en), 0);
    chk("rst_buf", 32'(buf_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;

    // Single requester: burst of 4, IDLE gap, burst of 2
    req_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      req_data[7:0] = 8'(8'h11 + i);
      #1;
      chk("t1_ready", 32'(req_ready), 1);
      chk("t1_busy", 32'(busy), (i == 0 || i == 4) ? 0 : 1);
      cyc();
      chk("t1_wr", 32'(wr_en), 1);
      chk("t1_buf", 32'(buf_in), 'h11 + i);
      chk("t1_gid", 32'(grant_id), 0);
    end
    req_valid = 4'b0000;
    #1 chk("t1_tail_busy", 32'(busy), 1);
    cyc();
    chk("t1_tail_wr", 32'(wr_en), 0);
    chk("t1_tail_idle", 32'(busy), 0);
    chk("t1_tail_buf", 32'(buf_in), 'h16);

    // All four requesters continuously: grants 0,1,2,3,0 of 4 beats each
    do_reset();
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      exp_id = (i / 4) % 4;
      #1 chk("t2_ready", 32'(req_ready), 1 << exp_id);
      cyc();
      chk("t2_gid", 32'(grant_id), exp_id);
      chk("t2_buf", 32'(buf_in), 'hA0 + exp_id);
      chk("t2_busy", 32'(busy), (i % 4 == 3) ? 0 : 1);
    end

    // Almost-full stall mid-burst
    do_reset();
    req_valid     = 4'b0001;
    req_data      = 32'h30;
    fifo_counter  = 4'd13;
    #1 chk("t3_ready13", 32'(req_ready), 1);
    cyc();
    chk("t3_busy1", 32'(busy), 1);
    cyc();
    chk("t3_wr2", 32'(wr_en), 1);
    fifo_counter = 4'd14;
    #1 chk("t3_ready14", 32'(req_ready), 0);
    chk("t3_busy14", 32'(busy), 1);
    repeat (2) begin
      cyc();
      chk("t3_stall_wr", 32'(wr_en), 0);
      chk("t3_stall_busy", 32'(busy), 1);
      chk("t3_stall_ready", 32'(req_ready), 0);
    end
    fifo_counter = 4'd12;
    #1 chk("t3_ready12", 32'(req_ready), 1);
    cyc();
    chk("t3_b3_wr", 32'(wr_en), 1);
    chk("t3_b3_busy", 32'(busy), 1);
    cyc();
    chk("t3_b4_wr", 32'(wr_en), 1);
    chk("t3_b4_idle", 32'(busy), 0);
    fifo_counter = 4'd0;

    // Owner 2 drops after 2 beats: next goes to 3 if valid, else wraps to 0
    drop_case(4'b1001, 3);
    drop_case(4'b0011, 0);

    // FIFO full with counter forced to zero
    do_reset();
    buf_full  = 1'b1;
    req_valid = 4'b1111;
    repeat (4) begin
      #1 chk("t5_ready", 32'(req_ready), 0);
      cyc();
      chk("t5_wr", 32'(wr_en), 0);
      chk("t5_busy", 32'(busy), 0);
    end
    buf_full = 1'b0;

    // Asynchronous reset during beat 3 of owner 2
    do_reset();
    req_data  = {8'h63, 8'h62, 8'h61, 8'h60};
    req_valid = 4'b0100;
    cyc();
    cyc();
    chk("t6_pre_wr", 32'(wr_en), 1);
    chk("t6_pre_busy", 32'(busy), 1);
    chk("t6_pre_gid", 32'(grant_id), 2);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_wr", 32'(wr_en), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    chk("t6_rst_gid", 32'(grant_id), 0);
    req_valid = 4'b1111;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_rel_wr", 32'(wr_en), 0);
    chk("t6_rel_ready", 32'(req_ready), 1);
    cyc();
    chk("t6_first_gid", 32'(grant_id), 0);
    chk("t6_first_wr", 32'(wr_en), 1);
    chk("t6_first_buf", 32'(buf_in), 'h60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of producers sharing the FIFO write port (2..8).
REQ-002 SHALL have parameter DW, default 8, data width matching buf_in.
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum consecutive beats per grant (1..15).
REQ-004 SHALL have parameter AF_TH, default 14, fifo_counter level at which new writes are withheld.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk and rst.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, NREQ bits: producer i has a byte.
REQ-009 SHALL have port req_data, input, NREQ*DW bits: producer i data in bits [i*DW +: DW].
REQ-010 SHALL have port req_ready, output, NREQ bits: producer i is accepted this cycle (combinational).
REQ-011 SHALL have port wr_en, output, 1 bit: registered FIFO write strobe.
REQ-012 SHALL have port buf_in, output, DW bits: registered FIFO write data.
REQ-013 SHALL have port buf_full, input, 1 bit: FIFO full flag.
REQ-014 SHALL have port fifo_counter, input, 4 bits: FIFO occupancy.
REQ-015 SHALL have port grant_id, output, $clog2(NREQ) bits: current or last owner.
REQ-016 SHALL have port busy, output, 1 bit: high while in state BURST.

Function
REQ-017 SHALL define space_ok = !buf_full && (fifo_counter < AF_TH).
REQ-018 SHALL define transfer on producer i as req_valid[i] && req_ready[i]; at most one req_ready bit is high per cycle.
REQ-019 SHALL register each transfer: next cycle wr_en=1 and buf_in=that producer's data; otherwise wr_en=0 and buf_in holds its value (1-cycle latency).
REQ-020 SHALL implement states IDLE and BURST, with rr pointer ptr, owner register, and beat counter beat.
REQ-021 In IDLE, the block SHALL select the first valid producer searching from ptr upward modulo NREQ, and assert its req_ready iff space_ok.
REQ-022 An IDLE transfer SHALL set owner=winner, grant_id=winner, and beat=1, then go to BURST, unless BURST_LEN==1, in which case it stays IDLE with ptr=winner+1.
REQ-023 In BURST, req_ready[owner] SHALL equal space_ok, and all other ready bits SHALL be 0.
REQ-024 A BURST transfer SHALL increment beat; when beat reaches BURST_LEN, the next state SHALL be IDLE with ptr=owner+1 mod NREQ.
REQ-025 In BURST with req_valid[owner]==0, the block SHALL go to IDLE next cycle with ptr=owner+1, and no transfer occurs.
REQ-026 In BURST with space_ok==0 and owner valid, the block SHALL stall: state, beat and owner hold, no ready.
REQ-027 If space_ok drops in IDLE, no ready SHALL assert, and ptr and state hold.
REQ-028 The ptr wrap from NREQ-1 SHALL go to 0; beat SHALL never exceed BURST_LEN.
REQ-029 The block SHALL never issue a write while buf_full is high at the accepting cycle.

Reset
REQ-030 While rst==0 (asynchronous), the block SHALL force: wr_en=0, buf_in=0, state=IDLE, ptr=0, owner=0, beat=0, grant_id=0, busy=0, req_ready=0.
REQ-031 A reset asserted mid-burst SHALL drop the in-flight grant; after release, arbitration restarts from ptr=0, and no write is issued in the first cycle after release.

Verification
REQ-032 Bench SHALL cover single requester: req_valid=4'b0001, data 0x11..0x16, FIFO empty -> wr_en 1 cycle after each accept; bursts of 4 and 2 with a 1-cycle IDLE gap between them; buf_in sequence 0x11..0x16.
REQ-033 Bench SHALL cover all four requesters valid continuously -> grant order 0,1,2,3,0; each grant is exactly 4 beats; grant_id follows the same order.
REQ-034 Bench SHALL cover fifo_counter=13 rising to 14 mid-burst -> req_ready drops the same cycle; busy stays 1; beat holds; resumes when fifo_counter=12.
REQ-035 Bench SHALL cover owner 2 dropping req_valid after 2 beats -> IDLE next cycle; next grant goes to 3 if valid, else 0.
REQ-036 Bench SHALL cover buf_full=1 with fifo_counter=0 (forced) -> no req_ready and no wr_en for the duration.
REQ-037 Bench SHALL cover rst pulled low between clock edges during beat 3 -> wr_en and busy go 0 immediately; after release, requester 0 wins first.
